// File: rtl/sevenseg_scanner.sv
// Four-digit multiplexed seven-segment scanner with double-buffered display data.
// Slots rotate every REFRESH_DIV cycles; new data is applied only at frame boundaries.
module sevenseg_scanner #(
    parameter int unsigned REFRESH_DIV = 100_000,
    parameter int unsigned DEAD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  blank_mask,
    output logic [6:0]  seven_segment,
    output logic [3:0]  anodes,
    output logic [1:0]  digit_sel,
    output logic        frame_done
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_LIM = CNT_W'(DEAD_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic             slot_tick_c;
    logic             frame_tick_c;

    logic [15:0]      shadow_val;
    logic [3:0]       shadow_blank;
    logic             pending;
    logic [15:0]      disp_val;
    logic [3:0]       disp_blank;

    logic [3:0]       nibble;
    logic             lit;
    logic [6:0]       seg_nxt;
    logic [3:0]       anodes_nxt;

    assign slot_tick_c  = (cnt == CNT_MAX);
    assign frame_tick_c = slot_tick_c && (digit_sel == 2'd3);

    // Refresh counter and digit slot rotation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            digit_sel  <= 2'd0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_tick_c;
            if (slot_tick_c) begin
                cnt       <= '0;
                digit_sel <= digit_sel + 2'd1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Shadow capture and frame-aligned transfer into the display register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_val   <= 16'h0000;
            shadow_blank <= 4'h0;
            pending      <= 1'b0;
            disp_val     <= 16'h0000;
            disp_blank   <= 4'h0;
        end else if (load && frame_tick_c) begin
            // Load on the boundary bypasses the shadow; anything older is superseded.
            disp_val   <= value;
            disp_blank <= blank_mask;
            pending    <= 1'b0;
        end else if (load) begin
            shadow_val   <= value;
            shadow_blank <= blank_mask;
            pending      <= 1'b1;
        end else if (frame_tick_c && pending) begin
            disp_val   <= shadow_val;
            disp_blank <= shadow_blank;
            pending    <= 1'b0;
        end
    end

    // Next segment/anode pattern for the slot currently in progress
    always_comb begin
        nibble     = 4'h0;
        lit        = 1'b0;
        seg_nxt    = 7'h7F;
        anodes_nxt = 4'hF;

        case (digit_sel)
            2'd0:    nibble = disp_val[3:0];
            2'd1:    nibble = disp_val[7:4];
            2'd2:    nibble = disp_val[11:8];
            default: nibble = disp_val[15:12];
        endcase

        lit = (cnt >= DEAD_LIM) && !disp_blank[digit_sel];

        if (lit) begin
            anodes_nxt = ~(4'b0001 << digit_sel);
            case (nibble)
                4'h0:    seg_nxt = 7'h40;
                4'h1:    seg_nxt = 7'h79;
                4'h2:    seg_nxt = 7'h24;
                4'h3:    seg_nxt = 7'h30;
                4'h4:    seg_nxt = 7'h19;
                4'h5:    seg_nxt = 7'h12;
                4'h6:    seg_nxt = 7'h02;
                4'h7:    seg_nxt = 7'h78;
                4'h8:    seg_nxt = 7'h00;
                4'h9:    seg_nxt = 7'h10;
                4'hA:    seg_nxt = 7'h08;
                4'hB:    seg_nxt = 7'h03;
                4'hC:    seg_nxt = 7'h46;
                4'hD:    seg_nxt = 7'h21;
                4'hE:    seg_nxt = 7'h06;
                default: seg_nxt = 7'h0E;
            endcase
        end
    end

    // Registered display drive, one cycle behind counter/slot state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seven_segment <= 7'h7F;
            anodes        <= 4'hF;
        end else begin
            seven_segment <= seg_nxt;
            anodes        <= anodes_nxt;
        end
    end

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Directed bench for sevenseg_scanner with REFRESH_DIV=4, DEAD_CYCLES=1.
module tb_sevenseg_scanner;

    localparam int unsigned RD = 4;
    localparam int unsigned DC = 1;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  blank_mask;
    logic [6:0]  seven_segment;
    logic [3:0]  anodes;
    logic [1:0]  digit_sel;
    logic        frame_done;

    int          checks;
    int          failures;
    int          k;
    logic [15:0] exp_val;
    logic [3:0]  exp_blank;

    sevenseg_scanner #(.REFRESH_DIV(RD), .DEAD_CYCLES(DC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (load),
        .value         (value),
        .blank_mask    (blank_mask),
        .seven_segment (seven_segment),
        .anodes        (anodes),
        .digit_sel     (digit_sel),
        .frame_done    (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Active-low gfedcba patterns for each hex digit
    function automatic logic [6:0] dec(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[n];
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, expv);
        end
    endtask

    task automatic chk_reset_values();
        chk("rst_anodes", 16'(anodes), 16'h000F);
        chk("rst_segments", 16'(seven_segment), 16'h007F);
        chk("rst_digit_sel", 16'(digit_sel), 16'h0000);
        chk("rst_frame_done", 16'(frame_done), 16'h0000);
    endtask

    // Advance one clock; outputs now show the state of cycle k-1 after reset release
    task automatic tick_check();
        int         g;
        int         c;
        int         s;
        logic       lit;
        logic [3:0] ea;
        logic [6:0] es;
        logic [3:0] nib;
        @(posedge clk);
        k++;
        @(negedge clk);
        g   = k - 1;
        c   = g % int'(RD);
        s   = (g / int'(RD)) % 4;
        lit = (c >= int'(DC)) && !exp_blank[s];
        nib = exp_val[s*4 +: 4];
        ea  = lit ? ~(4'b0001 << s) : 4'hF;
        es  = lit ? dec(nib) : 7'h7F;
        chk("anodes", 16'(anodes), 16'(ea));
        chk("segments", 16'(seven_segment), 16'(es));
        chk("digit_sel", 16'(digit_sel), 16'((k / int'(RD)) % 4));
        chk("frame_done", 16'(frame_done), 16'((k % (4 * int'(RD))) == 0));
    endtask

    task automatic run_to(input int target);
        while (k < target) tick_check();
    endtask

    // One-cycle load strobe sampled on the next rising edge
    task automatic load_tick(input logic [15:0] v, input logic [3:0] b);
        load       = 1'b1;
        value      = v;
        blank_mask = b;
        tick_check();
        load       = 1'b0;
        value      = 16'h0000;
        blank_mask = 4'h0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        k          = 0;
        exp_val    = 16'h0000;
        exp_blank  = 4'h0;
        rst_n      = 1'b0;
        load       = 1'b0;
        value      = 16'h0000;
        blank_mask = 4'h0;

        repeat (3) @(negedge clk);
        chk_reset_values();
        rst_n = 1'b1;

        // Idle scan after reset: digit 0 everywhere, frame pulse every 16 cycles
        run_to(32);

        // Load during slot 1; display only switches after the next frame boundary
        run_to(36);
        load_tick(16'h1A5F, 4'h0);
        run_to(48);
        exp_val = 16'h1A5F;
        run_to(64);

        // Two loads in one frame: last one wins, first never appears
        run_to(68);
        load_tick(16'h1111, 4'h0);
        run_to(72);
        load_tick(16'h2222, 4'h0);
        run_to(80);
        exp_val = 16'h2222;
        run_to(96);

        // Load coinciding with the 3->0 tick goes straight to the display
        run_to(111);
        load_tick(16'h0007, 4'h0);
        exp_val = 16'h0007;
        run_to(144);

        // Blank digits 1 and 3
        run_to(132 + 16);
        load_tick(16'h4321, 4'b1010);
        run_to(160);
        exp_val   = 16'h4321;
        exp_blank = 4'b1010;
        run_to(176);

        // Reset mid-slot 2 with a load still pending
        run_to(184);
        load_tick(16'h8888, 4'h0);
        run_to(186);
        chk("pre_rst_anodes_lit", 16'(anodes), 16'h000B);
        rst_n = 1'b0;
        #1;
        chk_reset_values();
        repeat (2) @(negedge clk);
        chk_reset_values();
        rst_n     = 1'b1;
        k         = 0;
        exp_val   = 16'h0000;
        exp_blank = 4'h0;
        run_to(32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sevenseg_scanner.md
SEVENSEG_SCANNER -- requirements
Module: sevenseg_scanner

Interface
REQ-001 Parameter REFRESH_DIV, default 100_000: clk cycles per digit slot (1 kHz per digit at 100 MHz); legal range >= 4.
REQ-002 Parameter DEAD_CYCLES, default 2: cycles at the start of each slot with all anodes off (anti-ghosting); legal range 0..REFRESH_DIV-2.
REQ-003 The block SHALL have one clock, clk; reset is rst_n, asynchronous and active-low.
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 load  input  1  single-cycle strobe that captures value and blank_mask.
REQ-007 value  input  16  four hex nibbles; nibble k drives digit k, digit 0 = value[3:0] = rightmost display.
REQ-008 blank_mask  input  4  bit k = 1 blanks digit k.
REQ-009 seven_segment  output  7  active-low segments, order gfedcba, MSB = g; registered.
REQ-010 anodes  output  4  active-low digit enables; bit 0 = rightmost digit; registered.
REQ-011 digit_sel  output  2  index of the digit slot currently in progress.
REQ-012 frame_done  output  1  one-cycle pulse when slot 3 ends and slot 0 begins.

Function
REQ-013 A refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; the wrap cycle is the slot tick.
REQ-014 On each slot tick, digit_sel SHALL increment modulo 4 (3 -> 0).
REQ-015 On load, value and blank_mask SHALL be captured into a shadow register and a pending flag set; a later load before apply overwrites the shadow (last wins).
REQ-016 The display register SHALL take the shadow contents only on the 3 -> 0 tick while pending is set; pending then clears. The displayed value never changes mid-frame.
REQ-017 If load coincides with the 3 -> 0 tick, the new load data SHALL go directly into the display register and pending SHALL end cleared.
REQ-018 For slot k, once the counter >= DEAD_CYCLES and blank bit k is 0: anodes = all ones except bit k = 0; seven_segment = decode(nibble k).
REQ-019 When counter < DEAD_CYCLES, or blank bit k is 1: anodes = 4'b1111 and seven_segment = 7'b111_1111.
REQ-020 Decode (hex, gfedcba, active-low): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
REQ-021 seven_segment and anodes SHALL be registered; they reflect counter and digit_sel state with exactly one cycle of latency.
REQ-022 frame_done SHALL be registered and asserted exactly one cycle, in the same cycle digit_sel becomes 0.
REQ-023 The anodes output SHALL never have more than one bit low in any cycle.

Reset
REQ-024 While rst_n = 0: refresh counter = 0, digit_sel = 0, shadow = 0, display register = 0, blank registers = 0, pending = 0, frame_done = 0, anodes = 4'b1111, seven_segment = 7'b111_1111.
REQ-025 Assertion of rst_n mid-frame SHALL take effect immediately (asynchronously) and discard any pending load.
REQ-026 After rst_n deasserts, slot 0 SHALL begin from counter 0 and display digit value 0 (7'h40) once the dead time ends.

Verification (REFRESH_DIV=4, DEAD_CYCLES=1)
REQ-027 Reset then idle -> anodes cycle 1111, 1110 x3, 1111, 1101 x3, 1111, 1011 x3, 1111, 0111 x3; segments 7'h40 in every lit cycle; frame_done pulses every 16 cycles.
REQ-028 Load value = 16'h1A5F, blank = 0, in slot 1 -> display unchanged until frame_done, then digits 0..3 show 0E, 12, 08, 79.
REQ-029 Two loads in one frame (16'h1111, then 16'h2222) -> only 2222 is displayed after the next frame boundary; 1111 is never shown.
REQ-030 Load 16'h0007 on the exact 3 -> 0 tick -> slot 0 of the new frame shows 7'h78; pending is clear afterwards.
REQ-031 blank_mask = 4'b1010 -> anodes bits 1 and 3 are never low; those slots output 7'h7F.
REQ-032 Pulse rst_n low mid-slot 2 with a load pending -> outputs reach reset values asynchronously; after release the display shows 0, not the pending data.
